// File: rtl/comm_epp_host_pkg.sv
// Shared command codes, FSM encoding and counter sizing helpers for the EPP host.
package comm_epp_pkg;

    localparam int DATA_W  = 8;
    localparam int STATE_W = 3;

    localparam logic [1:0] CMD_ADDR_WR = 2'b00;
    localparam logic [1:0] CMD_DATA_WR = 2'b01;
    localparam logic [1:0] CMD_DATA_RD = 2'b10;

    localparam logic [STATE_W-1:0] IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] SETUP   = 3'd1;
    localparam logic [STATE_W-1:0] STROBE  = 3'd2;
    localparam logic [STATE_W-1:0] RELEASE = 3'd3;
    localparam logic [STATE_W-1:0] RECOVER = 3'd4;

    typedef struct packed {
        logic [1:0]        cmdType;
        logic [DATA_W-1:0] cmdData;
    } epp_cmd_t;

    // Bits needed for a counter that runs 0 .. n-1.
    function automatic int cntWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The reserved code 2'b11 behaves as a data read.
    function automatic logic isWriteCmd(input logic [1:0] t);
        case (t)
            CMD_ADDR_WR, CMD_DATA_WR: return 1'b1;
            CMD_DATA_RD:              return 1'b0;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/comm_epp_host_if.sv
// Command/response stream between on-chip logic (master) and the EPP host (slave).
interface comm_epp_host_if;
    import comm_epp_pkg::*;

    logic [1:0]        cmdType_in;
    logic [DATA_W-1:0] cmdData_in;
    logic              cmdValid_in;
    logic              cmdReady_out;
    logic [DATA_W-1:0] rspData_out;
    logic              rspErr_out;
    logic              rspValid_out;
    logic              rspReady_in;

    modport master (
        output cmdType_in, cmdData_in, cmdValid_in, rspReady_in,
        input  cmdReady_out, rspData_out, rspErr_out, rspValid_out
    );

    modport slave (
        input  cmdType_in, cmdData_in, cmdValid_in, rspReady_in,
        output cmdReady_out, rspData_out, rspErr_out, rspValid_out
    );

endinterface

// File: rtl/comm_epp_host_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, resets to 0.
module sync_2ff (
    input  logic clk_in,
    input  logic reset_n_in,
    input  logic asyncBit_in,
    output logic syncBit_out
);
    logic meta_p0;
    logic sync_p1;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            meta_p0 <= asyncBit_in;
            sync_p1 <= meta_p0;
        end
    end

    assign syncBit_out = sync_p1;

endmodule

// File: rtl/comm_epp_host.sv
// EPP host: converts addr-write / data-write / data-read commands into EPP bus cycles.
// Optional strobe timeout is built when COMM_EPP_HOST_TIMEOUT_EN is defined.
module comm_epp_host
    import comm_epp_pkg::*;
#(
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_in,
    input  logic              reset_n_in,
    comm_epp_host_if.slave    cmd,
    inout  wire [DATA_W-1:0]  eppData_io,
    output logic              eppAddrStb_out,
    output logic              eppDataStb_out,
    output logic              eppWrite_out,
    input  logic              eppWait_in
);
    localparam int SETUP_N = (SETUP_CYCLES < 1) ? 1 : SETUP_CYCLES;
    localparam int TO_N    = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
    // One counter serves both the setup delay and the strobe timeout.
    localparam int CNT_W   = cntWidth(maxInt(SETUP_N, TO_N));

    logic [STATE_W-1:0] stateQ;
    epp_cmd_t           cmdQ;
    logic [CNT_W-1:0]   cntQ;
    logic               drvQ;
    logic               addrStbQ;
    logic               dataStbQ;
    logic               writeQ;
    logic               rspValidQ;
    logic [DATA_W-1:0]  rspDataQ;
    logic               waitSync;
    logic               cmdReady;
    logic               cmdFire;
    logic               cmdIsWr;
    logic               setupDone;
    logic               busDrive;

    sync_2ff uWaitSync (
        .clk_in      (clk_in),
        .reset_n_in  (reset_n_in),
        .asyncBit_in (eppWait_in),
        .syncBit_out (waitSync)
    );

    assign cmdReady  = (stateQ == IDLE) && !rspValidQ;
    assign cmdFire   = cmd.cmdValid_in && cmdReady;
    assign cmdIsWr   = isWriteCmd(cmdQ.cmdType);
    assign setupDone = (cntQ == CNT_W'(SETUP_N - 1));

    // drvQ only rises a clock after eppWrite_out fell, so the peripheral has
    // already turned its driver off before we drive the bus.
    assign busDrive   = drvQ && ((stateQ == SETUP) || (stateQ == STROBE) || (stateQ == RELEASE));
    assign eppData_io = busDrive ? cmdQ.cmdData : {DATA_W{1'bz}};

    assign eppAddrStb_out   = addrStbQ;
    assign eppDataStb_out   = dataStbQ;
    assign eppWrite_out     = writeQ;
    assign cmd.cmdReady_out = cmdReady;
    assign cmd.rspValid_out = rspValidQ;
    assign cmd.rspData_out  = rspDataQ;

`ifdef COMM_EPP_HOST_TIMEOUT_EN
    logic toQ;
    logic rspErrQ;
    assign cmd.rspErr_out = rspErrQ;
`else
    assign cmd.rspErr_out = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (cmdFire) begin
            cmdQ <= '{cmdType: cmd.cmdType_in, cmdData: cmd.cmdData_in};
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            stateQ    <= IDLE;
            cntQ      <= '0;
            drvQ      <= 1'b0;
            addrStbQ  <= 1'b1;
            dataStbQ  <= 1'b1;
            writeQ    <= 1'b1;
            rspValidQ <= 1'b0;
            rspDataQ  <= '0;
`ifdef COMM_EPP_HOST_TIMEOUT_EN
            toQ       <= 1'b0;
            rspErrQ   <= 1'b0;
`endif
        end else begin
            if (rspValidQ && cmd.rspReady_in) begin
                rspValidQ <= 1'b0;
`ifdef COMM_EPP_HOST_TIMEOUT_EN
                rspErrQ   <= 1'b0;
`endif
            end

            case (stateQ)
                IDLE: begin
                    if (cmdFire) begin
                        writeQ <= !isWriteCmd(cmd.cmdType_in);
                        cntQ   <= '0;
                        stateQ <= SETUP;
`ifdef COMM_EPP_HOST_TIMEOUT_EN
                        toQ    <= 1'b0;
`endif
                    end
                end

                SETUP: begin
                    drvQ <= cmdIsWr;
                    if (!setupDone) begin
                        cntQ <= cntQ + CNT_W'(1);
                    end else if (!waitSync && (drvQ || !cmdIsWr)) begin
                        // A wait still high from the last cycle holds us here.
                        addrStbQ <= (cmdQ.cmdType != CMD_ADDR_WR);
                        dataStbQ <= (cmdQ.cmdType == CMD_ADDR_WR);
                        cntQ     <= '0;
                        stateQ   <= STROBE;
                    end
                end

                STROBE: begin
                    if (waitSync) begin
                        if (!cmdIsWr) begin
                            rspDataQ <= eppData_io;
                        end
                        addrStbQ <= 1'b1;
                        dataStbQ <= 1'b1;
                        stateQ   <= RELEASE;
`ifdef COMM_EPP_HOST_TIMEOUT_EN
                    end else if (cntQ == CNT_W'(TO_N - 1)) begin
                        if (!cmdIsWr) begin
                            rspDataQ <= '0;
                        end
                        toQ      <= 1'b1;
                        addrStbQ <= 1'b1;
                        dataStbQ <= 1'b1;
                        stateQ   <= RELEASE;
                    end else begin
                        cntQ <= cntQ + CNT_W'(1);
`endif
                    end
                end

                RELEASE: begin
                    stateQ <= RECOVER;
                end

                RECOVER: begin
                    if (!waitSync) begin
                        writeQ <= 1'b1;
                        drvQ   <= 1'b0;
                        stateQ <= IDLE;
                        if (!cmdIsWr) begin
                            rspValidQ <= 1'b1;
`ifdef COMM_EPP_HOST_TIMEOUT_EN
                            rspErrQ   <= toQ;
`endif
                        end
                    end
                end

                default: begin
                    stateQ <= IDLE;
                end
            endcase
        end
    end

endmodule
